// File: rtl/cpu_sram_axi_bridge_if.sv
// Port bundles for cpu_sram_axi_bridge: the CPU SRAM-like inst/data side and the AXI master side.
interface cpu_sram_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata
  );
  modport slave (
    input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata
  );
endinterface

interface bridge_axi_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bvalid
  );
  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/cpu_sram_axi_bridge.sv
// CPU SRAM-like inst/data ports onto one AXI master: shared AR/R for reads, AW/W/B for stores.
// Define BRIDGE_RDATA_REG_EN to register rdata and both data_ok pulses (+1 cycle response).
module cpu_sram_axi_bridge #(
  parameter bit DATA_PRIO = 1'b1
) (
  input logic          clk,
  input logic          resetn,
  cpu_sram_if.slave    cpu,
  bridge_axi_if.master axi
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;

  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  logic [31:0] araddr_q, araddr_d;
  logic        r_src_q, r_src_d;   // 1: the read in flight belongs to the data port
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic data_rd, data_wr, data_busy;
  logic rd_data_win, rd_inst_win, wr_acc;
  logic aw_fire, w_fire, r_fire, b_fire;

  always_comb begin
    data_rd     = cpu.data_req && (cpu.data_wen == 4'b0000);
    data_wr     = cpu.data_req && (cpu.data_wen != 4'b0000);
    data_busy   = (w_state_q != W_IDLE) || ((r_state_q != R_IDLE) && r_src_q);
    rd_data_win = resetn && (r_state_q == R_IDLE) && data_rd && !data_busy &&
                  (DATA_PRIO || !cpu.inst_req);
    rd_inst_win = resetn && (r_state_q == R_IDLE) && cpu.inst_req && !rd_data_win;
    wr_acc      = resetn && (w_state_q == W_IDLE) && data_wr && !data_busy;
  end

  assign cpu.inst_addr_ok = rd_inst_win;
  assign cpu.data_addr_ok = rd_data_win || wr_acc;

  assign axi.araddr  = araddr_q;
  assign axi.arvalid = (r_state_q == R_AR);
  assign axi.rready  = (r_state_q == R_R);
  assign axi.awaddr  = awaddr_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.awvalid = (w_state_q == W_SEND) && !aw_done_q;
  assign axi.wvalid  = (w_state_q == W_SEND) && !w_done_q;
  assign axi.bready  = (w_state_q == W_RESP);

  assign aw_fire = axi.awvalid && axi.awready;
  assign w_fire  = axi.wvalid && axi.wready;
  assign r_fire  = axi.rready && axi.rvalid;
  assign b_fire  = axi.bready && axi.bvalid;

  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    r_src_d   = r_src_q;
    case (r_state_q)
      R_IDLE: if (rd_data_win || rd_inst_win) begin
        r_state_d = R_AR;
        r_src_d   = rd_data_win;
        araddr_d  = rd_data_win ? cpu.data_addr : cpu.inst_addr;
      end
      R_AR:    if (axi.arready) r_state_d = R_R;
      R_R:     if (axi.rvalid) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // AW and W complete independently; B is only awaited once both have gone
  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: if (wr_acc) begin
        w_state_d = W_SEND;
        awaddr_d  = cpu.data_addr;
        wdata_d   = cpu.data_wdata;
        wstrb_d   = cpu.data_wen;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      W_SEND: begin
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if (aw_done_d && w_done_d) begin
          w_state_d = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_RESP:  if (axi.bvalid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      r_src_q   <= 1'b0;
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      r_src_q   <= r_src_d;
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef BRIDGE_RDATA_REG_EN
  logic        inst_ok_q, inst_ok_d, data_ok_q, data_ok_d;
  logic [31:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;

  always_comb begin
    inst_ok_d    = r_fire && !r_src_q;
    data_ok_d    = (r_fire && r_src_q) || b_fire;
    inst_rdata_d = inst_ok_d ? axi.rdata : inst_rdata_q;
    data_rdata_d = (r_fire && r_src_q) ? axi.rdata : data_rdata_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign cpu.inst_data_ok = inst_ok_q;
  assign cpu.data_data_ok = data_ok_q;
  assign cpu.inst_rdata   = inst_rdata_q;
  assign cpu.data_rdata   = data_rdata_q;
`else
  assign cpu.inst_data_ok = r_fire && !r_src_q;
  assign cpu.data_data_ok = (r_fire && r_src_q) || b_fire;
  assign cpu.inst_rdata   = axi.rdata;
  assign cpu.data_rdata   = axi.rdata;
`endif

endmodule
